// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: trapezoidal-ramp step pulse sequencer for one stepper driver channel
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd_steps/cmd_dir move command;
//        abort stops the move; rotate_pulse/direction/module_enable/vref_level drive the motor driver;
//        busy/done/aborted/steps_remaining report progress.
// Build option: define STEPPER_POSITION_EN to add the signed 32-bit position output.
module stepper_move_ctrl #(
    parameter int STEP_W = 16,
    parameter int PERIOD_W = 20,
    parameter int START_PERIOD = 2000,
    parameter int MIN_PERIOD = 400,
    parameter int ACCEL_DELTA = 50,
    parameter int PULSE_HIGH = 4,
    parameter int HOLD_CYCLES = 100000,
    parameter logic [3:0] RUN_VREF = 4'd12,
    parameter logic [3:0] HOLD_VREF = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic              abort,
    output logic              rotate_pulse,
    output logic              direction,
    output logic              module_enable,
    output logic [3:0]        vref_level,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_remaining
`ifdef STEPPER_POSITION_EN
    ,
    output logic signed [31:0] position
`endif
);
    localparam logic [PERIOD_W-1:0] SP = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] MP = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] AD = PERIOD_W'(ACCEL_DELTA);
    localparam logic [PERIOD_W-1:0] PH_END = PERIOD_W'(PULSE_HIGH - 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, FINISH} state_t;

    state_t state, state_n;
    logic [PERIOD_W-1:0] cur_period, cur_period_n, cnt, up, dn;
    logic [STEP_W-1:0] accel_count, accel_count_n, rem_n;
    logic [HOLD_W-1:0] hold_t;
    logic moving, accept, fire, pulse_end, finish_now;

    assign moving = state == ACCEL || state == CRUISE || state == DECEL;
    assign cmd_ready = state == IDLE && !done;
    assign accept = cmd_valid && cmd_ready;
    // cnt counts cycles since the last rising edge (or since accept)
    assign fire = moving && !abort && cnt == cur_period - PERIOD_W'(1);
    assign pulse_end = rotate_pulse && cnt == PH_END;
    assign finish_now = state == FINISH && (!rotate_pulse || pulse_end);
    assign rem_n = steps_remaining - STEP_W'(1);
    // saturating ramp steps written as differences so they can never wrap
    assign up = (SP - cur_period <= AD) ? SP : cur_period + AD;
    assign dn = (cur_period - MP <= AD) ? MP : cur_period - AD;

    always_comb begin
        state_n = state;
        cur_period_n = cur_period;
        accel_count_n = accel_count;
        case (state)
            IDLE: if (accept) begin
                state_n = (cmd_steps == '0) ? FINISH : ACCEL;
                cur_period_n = SP;
                accel_count_n = '0;
            end
            ACCEL, CRUISE, DECEL: begin
                if (abort) state_n = FINISH;
                else if (fire) begin
                    if (rem_n == '0) state_n = FINISH;
                    else if (state != DECEL && rem_n <= accel_count) begin
                        state_n = DECEL;
                        cur_period_n = up;
                    end else if (state == ACCEL) begin
                        cur_period_n = dn;
                        accel_count_n = accel_count + STEP_W'(1);
                        state_n = (dn == MP) ? CRUISE : ACCEL;
                    end else if (state == DECEL) cur_period_n = up;
                end
            end
            FINISH: if (finish_now) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur_period <= SP;
            accel_count <= '0;
            cnt <= '0;
            hold_t <= '0;
            rotate_pulse <= 1'b0;
            direction <= 1'b0;
            module_enable <= 1'b0;
            vref_level <= 4'd0;
            busy <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
            steps_remaining <= '0;
        end else begin
            state <= state_n;
            cur_period <= cur_period_n;
            accel_count <= accel_count_n;
            cnt <= (accept || fire) ? '0 : cnt + PERIOD_W'(1);
            rotate_pulse <= fire || (rotate_pulse && !pulse_end);
            done <= finish_now;
            if (accept) begin
                direction <= cmd_dir;
                steps_remaining <= cmd_steps;
                module_enable <= 1'b1;
                vref_level <= RUN_VREF;
                busy <= 1'b1;
                aborted <= 1'b0;
                hold_t <= '0;
            end else begin
                if (fire) steps_remaining <= rem_n;
                if (moving && abort) aborted <= 1'b1;
                if (finish_now) busy <= 1'b0;
                if (state == IDLE && hold_t != HOLD_MAX) hold_t <= hold_t + HOLD_W'(1);
                // hold current only applies once the driver has been enabled by a move
                if (state == IDLE && module_enable && hold_t == HOLD_LAST) vref_level <= HOLD_VREF;
            end
        end
    end

`ifdef STEPPER_POSITION_EN
    always_ff @(posedge clk) begin
        if (rst) position <= '0;
        else if (fire) position <= direction ? position + 32'sd1 : position - 32'sd1;
    end
`endif
endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb_stepper_move_ctrl: randomized self-checking bench for stepper_move_ctrl against a step-plan model
module tb_stepper_move_ctrl;
    localparam int SP = 20, MP = 8, AD = 4, PH = 2, HC = 50;

    logic clk = 0, rst = 1, cmd_valid = 0, cmd_dir = 0, abort = 0;
    logic [15:0] cmd_steps = 0;
    logic cmd_ready, rotate_pulse, direction, module_enable, busy, done, aborted;
    logic [3:0] vref_level;
    logic [15:0] steps_remaining;
`ifdef STEPPER_POSITION_EN
    logic signed [31:0] position;
`endif

    stepper_move_ctrl #(
        .START_PERIOD(SP), .MIN_PERIOD(MP), .ACCEL_DELTA(AD), .PULSE_HIGH(PH), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir), .abort(abort), .rotate_pulse(rotate_pulse), .direction(direction),
        .module_enable(module_enable), .vref_level(vref_level), .busy(busy), .done(done),
        .aborted(aborted), .steps_remaining(steps_remaining)
`ifdef STEPPER_POSITION_EN
        , .position(position)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cur_t = 0;
    int m_edges[$];
    int dut_edges[$];
    int dut_done_t;
    int exp_pos = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0d expected=%0d", name, cur_t, act, exp);
        end
    endtask

    // Rising-edge times (cycles after accept) derived directly from the ramp rules.
    function automatic void plan(int n);
        int t = 0, per = SP, ac = 0, rem = n, ph = 0;
        m_edges.delete();
        while (rem > 0) begin
            t += per;
            m_edges.push_back(t);
            rem--;
            if (rem == 0) break;
            if (ph != 2 && rem <= ac) begin
                ph = 2;
                per = (per + AD > SP) ? SP : per + AD;
            end else if (ph == 0) begin
                per = (per - AD < MP) ? MP : per - AD;
                ac++;
                if (per == MP) ph = 1;
            end else if (ph == 2) per = (per + AD > SP) ? SP : per + AD;
        end
    endfunction

    task automatic check_reset(string tag);
        chk({tag, "_pulse"}, rotate_pulse, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_dir"}, direction, 0);
        chk({tag, "_en"}, module_enable, 0);
        chk({tag, "_vref"}, vref_level, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_aborted"}, aborted, 0);
        chk({tag, "_rem"}, steps_remaining, 0);
`ifdef STEPPER_POSITION_EN
        chk({tag, "_pos"}, position, 0);
`endif
    endtask

    // abort_at: abort is driven right after the sample at that cycle; rst_at likewise for reset.
    task automatic run_move(int n, bit dir, int abort_at, int rst_at, int idle);
        int d, k, last, pos0;
        bit high, prev;
        plan(n);
        if (abort_at >= 0) while (m_edges.size() > 0 && m_edges[$] > abort_at) void'(m_edges.pop_back());
        last = (m_edges.size() > 0) ? m_edges[$] + PH : 0;
        if (abort_at >= 0) d = (abort_at + 2 > last) ? abort_at + 2 : last;
        else d = (n == 0) ? 1 : last;
        dut_edges.delete();
        dut_done_t = -1;
        pos0 = exp_pos;
        prev = 0;
        cmd_steps = 16'(n);
        cmd_dir = dir;
        cmd_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        for (int t = 0; t <= d + idle; t++) begin
            if (t > 0) @(negedge clk);
            cur_t = t;
            k = 0;
            high = 0;
            foreach (m_edges[i]) begin
                if (m_edges[i] <= t) k++;
                if (m_edges[i] <= t && t < m_edges[i] + PH) high = 1;
            end
            chk("pulse", rotate_pulse, high);
            chk("done", done, t == d);
            chk("busy", busy, t < d);
            chk("ready", cmd_ready, t > d);
            chk("rem", steps_remaining, n - k);
            chk("dir", direction, dir);
            chk("enable", module_enable, 1);
            chk("vref", vref_level, (t - d >= HC) ? 4 : 12);
            chk("aborted", aborted, abort_at >= 0 && t > abort_at);
`ifdef STEPPER_POSITION_EN
            chk("position", position, dir ? pos0 + k : pos0 - k);
`endif
            if (rotate_pulse && !prev) dut_edges.push_back(t);
            if (done) dut_done_t = t;
            prev = rotate_pulse;
            abort = (t == abort_at);
            if (t == rst_at) begin
                rst = 1;
                break;
            end
        end
        exp_pos = dir ? pos0 + m_edges.size() : pos0 - m_edges.size();
        if (rst) begin
            @(negedge clk);
            rst = 0;
            abort = 0;
            check_reset("midrst");
            exp_pos = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("midrst_nodone", done, 0);
                chk("midrst_nopulse", rotate_pulse, 0);
            end
        end
    endtask

    task automatic chk_intervals(string name, int exp[]);
        chk({name, "_count"}, dut_edges.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_edges.size(); i++)
            chk(name, dut_edges[i] - ((i == 0) ? 0 : dut_edges[i-1]), exp[i]);
    endtask

    initial begin
        int n, ab, idle;
        bit dir;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 0;
        @(negedge clk);

        run_move(10, 1, -1, -1, 2);
        chk_intervals("iv10", '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20});
        chk("done10_t", dut_done_t, 130);

        run_move(4, 0, -1, -1, 60);
        chk_intervals("iv4", '{20, 16, 12, 16});
        chk("done4_t", dut_done_t, 66);

        run_move(0, 1, -1, -1, 3);
        chk("zero_edges", dut_edges.size(), 0);
        chk("zero_done_t", dut_done_t, 1);

        run_move(100, 1, 64, -1, 3);
        chk_intervals("iv_abort", '{20, 16, 12, 8, 8});
        chk("abort_rem", steps_remaining, 95);
        chk("abort_flag", aborted, 1);
        chk("abort_done_t", dut_done_t, 66);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 30);
            dir = 1'($urandom_range(0, 1));
            idle = $urandom_range(1, 60);
            ab = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) begin
                plan(n);
                ab = $urandom_range(0, m_edges[$] - 1);
            end
            run_move(n, dir, ab, -1, idle);
        end

        run_move(10, 1, -1, 60, 0);
        run_move(3, 0, -1, -1, 2);
        chk_intervals("iv3", '{20, 16, 20});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stepper_move_ctrl.md
Name: stepper_move_ctrl

Overview:
- Motion sequencer for one stepper driver channel.
- Accepts move commands (step count + direction) and generates a trapezoidal-ramped step pulse train on `rotate_pulse`.
- Also drives `direction`, `module_enable` (driver STANBY) and `vref_level` (run/hold current) into the downstream phase/PWM driver block.
- Sits between host/command logic and the motor driver on the same clock.

Parameters:
- STEP_W, 16, width of step count.
- PERIOD_W, 20, width of step-interval counter.
- START_PERIOD, 2000, interval in clk cycles at ramp start and end; must be ≥ MIN_PERIOD.
- MIN_PERIOD, 400, cruise interval in clk cycles; must be > PULSE_HIGH.
- ACCEL_DELTA, 50, interval change per step during ramp.
- PULSE_HIGH, 4, rotate_pulse high width in clk cycles; must be ≥ 1.
- HOLD_CYCLES, 100000, idle cycles after a move before dropping to hold current.
- RUN_VREF, 4'd12, vref_level while moving.
- HOLD_VREF, 4'd4, vref_level when holding.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  move command offered
- cmd_ready  out  1  high only in IDLE
- cmd_steps  in  STEP_W  steps to move
- cmd_dir  in  1  direction, 1 = forward
- abort  in  1  stop the current move
- rotate_pulse  out  1  step clock to driver
- direction  out  1  latched cmd_dir
- module_enable  out  1  driver enable
- vref_level  out  4  current level
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at move end
- aborted  out  1  sticky; set if the last move was aborted
- steps_remaining  out  STEP_W  live count

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State goes to IDLE, hold timer cleared, cur_period=START_PERIOD, accel_count=0.
- rst mid-move drops rotate_pulse in the next cycle; no done pulse is produced.
- States: IDLE, ACCEL, CRUISE, DECEL, FINISH.
- Command accept: cmd_valid & cmd_ready in IDLE. At accept:
  - latch direction=cmd_dir and steps_remaining=cmd_steps
  - set module_enable=1, vref_level=RUN_VREF, busy=1, aborted=0
  - set cur_period=START_PERIOD, accel_count=0, go to ACCEL
- Zero-step command (cmd_steps=0): go to FINISH instead; no pulse is issued.
- Pulse timing:
  - First rotate_pulse rising edge occurs exactly START_PERIOD cycles after the accept cycle.
  - Subsequent rising edges are exactly cur_period cycles apart.
  - Each pulse stays high PULSE_HIGH cycles.
  - direction is stable from accept until busy falls.
- Per-step update, evaluated at each rising edge (steps_remaining decrements there):
  - rem==0: go to FINISH.
  - else if rem ≤ accel_count (in ACCEL or CRUISE): go to DECEL, cur_period += ACCEL_DELTA (saturate at START_PERIOD).
  - else if ACCEL: cur_period −= ACCEL_DELTA (saturate at MIN_PERIOD), accel_count++; if result equals MIN_PERIOD, go to CRUISE.
  - DECEL: cur_period += ACCEL_DELTA (saturate at START_PERIOD).
- FINISH: waits for the last pulse to fall, then:
  - done=1 for one cycle, busy=0, go to IDLE
  - cmd_ready=1 from the following cycle
- abort in ACCEL/CRUISE/DECEL:
  - no further rising edges
  - an in-progress high phase completes its full PULSE_HIGH width
  - aborted=1, then FINISH behaviour; steps_remaining holds its value
- abort in IDLE is ignored. abort and accept in the same cycle: accept wins.
- Hold current:
  - in IDLE, hold timer counts; reaching HOLD_CYCLES sets vref_level=HOLD_VREF
  - a new accept restores RUN_VREF and clears the timer
  - module_enable stays 1 after the first move until rst
- Arithmetic is unsigned; the cur_period saturating ops must never wrap.

Optional Feature:
- Macro: STEPPER_POSITION_EN.
- Defined:
  - adds output `position` (signed 32-bit, reset 0)
  - incremented on each rising edge with direction=1, decremented with direction=0
  - wraps two's-complement
- Undefined: no position port and no counter logic.

Test Plan:
- Test overrides for all scenarios: START_PERIOD=20, MIN_PERIOD=8, ACCEL_DELTA=4, PULSE_HIGH=2, HOLD_CYCLES=50.
- 10-step forward move:
  - rising-edge intervals (first from accept) are 20,16,12,8,8,8,8,12,16,20
  - each pulse is 2 cycles high, direction=1
  - done is a single pulse 2 cycles after the 10th rising edge; steps_remaining=0
- 4-step reverse move:
  - intervals 20,16,12,16, direction=0
  - states seen: ACCEL, then DECEL, never CRUISE
- cmd_steps=0: no rotate_pulse, done within 2 cycles of accept, busy falls, vref_level=12.
- 100-step move, abort asserted mid-pulse at the 5th rising edge +1 cycle:
  - pulse completes its 2-cycle width, no 6th edge
  - aborted=1, steps_remaining=95, done pulses once
- After any move, 50 idle cycles: vref_level goes 12→4. A new cmd_valid is accepted the next cycle and vref_level returns to 12.
- rst asserted during CRUISE: next cycle all outputs are at reset values, cmd_ready=1, no done pulse. With STEPPER_POSITION_EN, position=0.
